nfi_rate_controller: RTL and testbench

//  Parametrised successor of the next-frame-iteration (NFI) go-pulse controller for the Game of Life engine.

---
 rtl/gol_ctrl_pkg.sv | 25 ++
 rtl/nfi_period_timer.sv | 32 +++
 rtl/nfi_rate_controller.sv | 143 ++++++++++++++
 tb/tb_nfi_rate_controller.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gol_ctrl_pkg.sv
// Shared types and helpers for the Game of Life iteration-rate controller.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package gol_ctrl_pkg;

    // Controller run state; PAUSED only advances on an explicit single step.
    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } nfi_state_t;

    // One cycle's worth of UI commands, grouped so they travel together.
    typedef struct packed {
        logic toggle;
        logic step;
        logic up;
        logic down;
    } nfi_cmd_t;

    // Period in clk cycles for speed index s; index 0 is the slowest rate.
    function automatic int nfi_period(input int base, input int n, input int s);
        return base << (n - 1 - s);
    endfunction

endpackage

// File: rtl/nfi_period_timer.sv
// Free-running period timer that parks at its terminal value until cleared.
// Latency: at_term is combinational from the registered count.
// Backpressure: the owner withholds clr to keep the count parked at period-1.
module nfi_period_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W:0]   period,
    output logic             at_term
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   term;

    assign term    = period - (CNT_W+1)'(1);
    assign at_term = ({1'b0, cnt_q} == term);

    // Count up while enabled, park at period-1, restart from zero on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !at_term) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/nfi_rate_controller.sv
// Issues single-cycle go strobes to the life-grid engine at a selectable rate, with run/pause and single step.
// Latency: o_go rises on the clock edge where a due step meets i_NFI_allowed (registered, one strobe per grant).
// Backpressure: a due step waits for i_NFI_allowed; at most one step is ever owed, late grants never accumulate.
module nfi_rate_controller
    import gol_ctrl_pkg::*;
#(
    parameter int BASE_CNT     = 4,   // fastest period, must be >= 2
    parameter int N_SPEEDS     = 3,   // number of speed levels, must be >= 2
    parameter int GEN_CNT_W    = 8,
    parameter int START_PAUSED = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_NFI_allowed,
    input  logic                        i_cmd_toggle_pause,
    input  logic                        i_cmd_single_step,
    input  logic                        i_cmd_speed_up,
    input  logic                        i_cmd_speed_down,
    output logic                        o_go,
    output logic                        o_paused,
    output logic [$clog2(N_SPEEDS)-1:0] o_speed_idx,
    output logic [GEN_CNT_W-1:0]        o_gen_cnt
);

    localparam int SPD_W = $clog2(N_SPEEDS);
    localparam int MAX_P = BASE_CNT << (N_SPEEDS - 1);
    localparam int CNT_W = $clog2(MAX_P);
    localparam logic [SPD_W-1:0] SPD_MAX = SPD_W'(N_SPEEDS - 1);
    localparam nfi_state_t RST_STATE = (START_PAUSED != 0) ? PAUSED : RUN;

    nfi_cmd_t             cmd;
    nfi_state_t           state_q, state_d;
    logic                 step_pending_q, step_pending_d;
    logic [SPD_W-1:0]     speed_q, speed_d;
    logic [GEN_CNT_W-1:0] gen_q, gen_d;
    logic                 go_q, go_d;

    logic                 at_term;
    logic [CNT_W:0]       period;
    logic                 due;
    logic                 fire;
    logic                 up_ok;
    logic                 dn_ok;
    logic                 timer_clr;
    logic                 timer_en;

    assign cmd = '{toggle: i_cmd_toggle_pause,
                   step:   i_cmd_single_step,
                   up:     i_cmd_speed_up,
                   down:   i_cmd_speed_down};

    assign period = (CNT_W+1)'(nfi_period(BASE_CNT, N_SPEEDS, int'(speed_q)));

    // A go is owed when the RUN period has elapsed or a paused step is waiting;
    // a toggle on the same edge always wins and drops it.
    assign due  = ((state_q == RUN) && at_term) || step_pending_q;
    assign fire = due && i_NFI_allowed && !cmd.toggle;

    // Opposing speed commands cancel; saturated requests are not accepted.
    assign up_ok = cmd.up && !cmd.down && (speed_q != SPD_MAX);
    assign dn_ok = cmd.down && !cmd.up && (speed_q != '0);

    // Any accepted speed change restarts the period, dropping a waiting RUN go.
    assign timer_clr = cmd.toggle || fire || up_ok || dn_ok;
    assign timer_en  = (state_q == RUN);

    nfi_period_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .period  (period),
        .at_term (at_term)
    );

    // Next-state: run/pause transitions, step latch, speed, go and generation count.
    always_comb begin
        state_d        = state_q;
        step_pending_d = step_pending_q;
        speed_d        = speed_q;
        gen_d          = gen_q;
        go_d           = 1'b0;

        case (state_q)
            RUN: begin
                if (cmd.toggle) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (cmd.toggle) begin
                    state_d = RUN;
                end else if (cmd.step && !step_pending_q) begin
                    step_pending_d = 1'b1;
                end
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase

        if (cmd.toggle) begin
            step_pending_d = 1'b0;
        end

        if (fire) begin
            go_d           = 1'b1;
            step_pending_d = 1'b0;
            gen_d          = gen_q + GEN_CNT_W'(1);
        end

        if (up_ok) begin
            speed_d = speed_q + SPD_W'(1);
        end else if (dn_ok) begin
            speed_d = speed_q - SPD_W'(1);
        end
    end

    // Controller state registers; reset drops any owed go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RST_STATE;
            step_pending_q <= 1'b0;
            speed_q        <= '0;
            gen_q          <= '0;
            go_q           <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_pending_q <= step_pending_d;
            speed_q        <= speed_d;
            gen_q          <= gen_d;
            go_q           <= go_d;
        end
    end

    assign o_go        = go_q;
    assign o_paused    = (state_q == PAUSED);
    assign o_speed_idx = speed_q;
    assign o_gen_cnt   = gen_q;

endmodule

// File: tb/tb_nfi_rate_controller.sv
// Bench for the iteration-rate controller: one instance leaving reset in RUN, one in PAUSED.
// Expected go strobes are queued by the stimulus with hand-computed cycle numbers and checked by monitors.
// Status outputs are compared directly against hand-computed values at chosen points.
module tb_nfi_rate_controller;

    typedef struct {
        int cyc;
        int gen;
        int paused;
        int speed;
    } exp_t;

    localparam logic [3:0] C_TOG  = 4'b1000;
    localparam logic [3:0] C_STEP = 4'b0100;
    localparam logic [3:0] C_UP   = 4'b0010;
    localparam logic [3:0] C_DN   = 4'b0001;

    logic       clk;
    logic       rst_n;

    logic       allowed0, toggle0, step0, up0, down0;
    logic       go0, paused0;
    logic [1:0] speed0;
    logic [7:0] gen0;

    logic       allowed1, toggle1, step1, up1, down1;
    logic       go1, paused1;
    logic [1:0] speed1;
    logic [7:0] gen1;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;

    nfi_rate_controller #(
        .BASE_CNT(4), .N_SPEEDS(3), .GEN_CNT_W(8), .START_PAUSED(0)
    ) dut0 (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_NFI_allowed      (allowed0),
        .i_cmd_toggle_pause (toggle0),
        .i_cmd_single_step  (step0),
        .i_cmd_speed_up     (up0),
        .i_cmd_speed_down   (down0),
        .o_go               (go0),
        .o_paused           (paused0),
        .o_speed_idx        (speed0),
        .o_gen_cnt          (gen0)
    );

    nfi_rate_controller #(
        .BASE_CNT(4), .N_SPEEDS(3), .GEN_CNT_W(8), .START_PAUSED(1)
    ) dut1 (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_NFI_allowed      (allowed1),
        .i_cmd_toggle_pause (toggle1),
        .i_cmd_single_step  (step1),
        .i_cmd_speed_up     (up1),
        .i_cmd_speed_down   (down1),
        .o_go               (go1),
        .o_paused           (paused1),
        .o_speed_idx        (speed1),
        .o_gen_cnt          (gen1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: at a falling edge, cyc equals the number of rising edges seen.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push0(input int c, input int g, input int p, input int s);
        exp_t e;
        e.cyc = c; e.gen = g; e.paused = p; e.speed = s;
        q0.push_back(e);
    endtask

    task automatic push1(input int c, input int g, input int p, input int s);
        exp_t e;
        e.cyc = c; e.gen = g; e.paused = p; e.speed = s;
        q1.push_back(e);
    endtask

    // Monitor for the RUN-start instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (go0) begin
                check("go0_not_back_to_back", int'(prev0), 0);
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL go0_unexpected: got strobe at cyc %0d expected none", cyc);
                end else begin
                    e = q0.pop_front();
                    check("go0_cycle", cyc, e.cyc);
                    check("go0_gen", int'(gen0), e.gen);
                    check("go0_paused", int'(paused0), e.paused);
                    check("go0_speed", int'(speed0), e.speed);
                end
            end
            prev0 = go0;
        end else begin
            prev0 = 1'b0;
        end
    end

    // Monitor for the PAUSED-start instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (go1) begin
                check("go1_not_back_to_back", int'(prev1), 0);
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL go1_unexpected: got strobe at cyc %0d expected none", cyc);
                end else begin
                    e = q1.pop_front();
                    check("go1_cycle", cyc, e.cyc);
                    check("go1_gen", int'(gen1), e.gen);
                    check("go1_paused", int'(paused1), e.paused);
                    check("go1_speed", int'(speed1), e.speed);
                end
            end
            prev1 = go1;
        end else begin
            prev1 = 1'b0;
        end
    end

    // Command pulses: drive at a falling edge, sampled at the next rising edge.
    task automatic run0(input logic [3:0] c);
        {toggle0, step0, up0, down0} = c;
        @(negedge clk);
        {toggle0, step0, up0, down0} = 4'b0000;
    endtask

    task automatic idle0(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run1(input logic [3:0] c);
        {toggle1, step1, up1, down1} = c;
        @(negedge clk);
        {toggle1, step1, up1, down1} = 4'b0000;
    endtask

    task automatic idle1(input int n);
        repeat (n) @(negedge clk);
    endtask

    // RUN-start instance: rate, speed saturation, grant wait, toggle priority, async reset.
    task automatic seq0(input int c0);
        int m;
        int n;
        int r;
        for (int k = 1; k <= 6; k++) push0(c0 + 16 * k, k, 0, 0);
        idle0(100);
        check("a_speed", int'(speed0), 0);
        check("a_paused", int'(paused0), 0);
        check("a_gen", int'(gen0), 6);

        m = cyc;
        run0(C_UP);
        run0(C_UP);
        check("b_speed_up2", int'(speed0), 2);
        run0(C_UP);
        check("b_speed_sat", int'(speed0), 2);
        push0(m + 6, 7, 0, 2);
        push0(m + 10, 8, 0, 2);
        idle0(9);
        run0(C_DN);
        run0(C_DN);
        run0(C_DN);
        check("b_speed_down3", int'(speed0), 0);
        run0(C_UP);
        run0(C_UP);
        check("c_speed", int'(speed0), 2);

        allowed0 = 1'b0;
        idle0(20);
        allowed0 = 1'b1;
        push0(m + 38, 9, 0, 2);
        push0(m + 42, 10, 0, 2);
        idle0(7);

        n = cyc;
        check("d_gen", int'(gen0), 10);
        idle0(1);
        run0(C_TOG | C_STEP);
        check("d_paused", int'(paused0), 1);
        idle0(20);
        run0(C_TOG);
        check("d_resumed", int'(paused0), 0);
        push0(n + 27, 11, 0, 2);
        idle0(4);

        #2 rst_n = 1'b0;
        #1;
        check("rst_go0", int'(go0), 0);
        check("rst_gen0", int'(gen0), 0);
        check("rst_speed0", int'(speed0), 0);
        check("rst_paused0", int'(paused0), 0);
        check("rst_paused1", int'(paused1), 1);
        check("rst_gen1", int'(gen1), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        push0(r + 16, 1, 0, 0);
        idle0(20);
    endtask

    // PAUSED-start instance: no free running, single step, step cleared by toggle.
    task automatic seq1(input int c0);
        int s;
        idle1(50);
        check("e_paused", int'(paused1), 1);
        check("e_gen", int'(gen1), 0);
        s = cyc;
        push1(s + 2, 1, 1, 0);
        run1(C_STEP);
        idle1(1);
        allowed1 = 1'b0;
        run1(C_STEP);
        run1(C_TOG);
        allowed1 = 1'b1;
        push1(s + 20, 2, 0, 0);
        idle1(17);
        run1(C_TOG);
        check("f_paused", int'(paused1), 1);
        check("f_gen", int'(gen1), 2);
    endtask

    initial begin
        int c0;
        rst_n = 1'b0;
        {allowed0, toggle0, step0, up0, down0} = 5'b0;
        {allowed1, toggle1, step1, up1, down1} = 5'b0;
        repeat (3) @(negedge clk);
        check("init_go0", int'(go0), 0);
        check("init_gen0", int'(gen0), 0);
        check("init_speed0", int'(speed0), 0);
        check("init_paused0", int'(paused0), 0);
        check("init_go1", int'(go1), 0);
        check("init_paused1", int'(paused1), 1);

        allowed0 = 1'b1;
        allowed1 = 1'b1;
        rst_n    = 1'b1;
        c0       = cyc;
        fork
            seq0(c0);
            seq1(c0);
        join

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

endmodule
